irq_ctrl: RTL
=============

// Module: irq_ctrl
// PURPOSE
//   Interrupt controller that takes the level interrupt lines of the SoC peripherals
//   (GPIO_MOD.int on src 0, timer and UART on higher sources) and produces the single
//   external interrupt request seen by the RISC-V core.
//   Per-source enable and edge/level mode; fixed priority (lowest index wins).
//   Claim/complete handshake over the same 8-bit Wishbone-style slave port as the GPIO block.
// PARAMETERS
//   NSRC  4  number of interrupt sources, 1..8 (one bit per source in each register)
// PORTS
//   clk       in   1     clock
//   rstn      in   1     reset, asynchronous, active-low
//   irq_src   in   NSRC  raw interrupt lines, may be asynchronous to clk
//   addr      in   3     register select
//   i_wb_dat  in   8     write data
//   i_wb_we   in   1     write enable
//   i_wb_cyc  in   1     bus cycle request
//   o_wb_rdt  out  8     read data, combinational from addr and state
//   o_wb_ack  out  1     acknowledge
//   irq_o     out  1     interrupt request to the core, registered
// BEHAVIOUR
// - Reset (async, rstn=0): all register bits and flops are 0, o_wb_ack=0, irq_o=0, state IDLE.
//   Reset mid-claim discards the in-service id.
// - Synchroniser: irq_src passes 2 flops (s1, s2), then a third flop s3 for edge detect.
//   rise[i] = s2[i] & ~s3[i].
// - Register map (addr). Bits [7:NSRC] read 0 and ignore writes.
//   - 0 PEND (R/W1C): edge source = sticky latch, level source = s2 directly. W1C acts on edge sources only.
//   - 1 EN (RW).
//   - 2 EDGE (RW): 1 = rising-edge latched, 0 = level.
//   - 3 CLAIM (R = claim, W = complete).
//   - 4 INSVC (R): in-service id, 0 if none.
//   - 5..7 read 0, writes ignored.
// - Bus: o_wb_ack <= i_wb_cyc & ~o_wb_ack, giving a 1-cycle ack pulse and 1 wait state.
//   Register writes and read side-effects occur only on the clock edge where i_wb_cyc & o_wb_ack.
// - Edge PEND bit: next = (pend & ~w1c & ~claim_clr) | rise.
//   A rising edge in the same cycle as W1C or claim leaves the bit set.
//   Changing EDGE from 1 to 0 clears the latched bit.
// - Candidate: cand = PEND & EN; best = lowest set index of cand; id = best+1; id = 0 if cand==0.
// - FSM, states IDLE and INSVC:
//   - IDLE, read CLAIM: o_wb_rdt = id.
//     - If id!=0: go to INSVC, record id, clear that PEND bit if the source is in edge mode.
//     - If id==0: no state change.
//   - INSVC, read CLAIM: returns 0, no side-effect (no nesting).
//   - INSVC, write CLAIM with i_wb_dat == recorded id: complete, go to IDLE, INSVC reads 0.
//     Any other write value is ignored.
//   - IDLE, write CLAIM: ignored.
// - irq_o <= (state==IDLE) & (cand!=0). Falls the cycle after a successful claim.
// - Level source still high at complete: irq_o re-asserts 1 cycle after return to IDLE.
// - Latency: irq_src rises before edge k -> PEND set at edge k+2 -> irq_o=1 after edge k+3.
// - EN cleared while pending: the source drops out of cand. An edge-mode PEND bit stays latched.
// TESTING
// - Reset with irq_src=4'hF: all registers read 0, irq_o=0, o_wb_ack=0.
//   Release reset: PEND reads 4'hF (level mode), irq_o stays 0 because EN=0.
// - EN=4'h5, EDGE=0, pulse src2 high: irq_o=1 exactly 4 cycles after the rise.
//   CLAIM read returns 3, irq_o=0 next cycle.
//   Write CLAIM=3 with src2 still high: irq_o back to 1. Drop src2: irq_o=0.
// - EDGE=4'hF, EN=4'hF, single-cycle-wide pulses on src1 and src3: PEND=4'hA.
//   CLAIM read -> 2 and PEND=4'h8. Complete with 2. CLAIM read -> 4, PEND=0.
// - INSVC=2: second CLAIM read returns 0 and INSVC still reads 2.
//   Write CLAIM=1 is ignored (INSVC=2); write CLAIM=2 -> INSVC=0.
// - Edge source 0: rise in the same cycle as PEND W1C=8'h01 -> bit 0 remains 1.
//   Later W1C with no edge -> PEND=0. W1C on a level source has no effect.
// - Assert rstn=0 while INSVC=3 and PEND!=0: everything 0 immediately (async).
//   After release, a CLAIM read with no sources returns 0.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source enable and edge/level mode, fixed
// priority (lowest index wins), claim/complete over an 8-bit slave port.
module irq_ctrl #(
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NSRC-1:0] irq_src,
  input  logic [2:0]      addr,
  input  logic [7:0]      i_wb_dat,
  input  logic            i_wb_we,
  input  logic            i_wb_cyc,
  output logic [7:0]      o_wb_rdt,
  output logic            o_wb_ack,
  output logic            irq_o
);

  typedef enum logic {
    IDLE,
    INSVC
  } state_e;

  state_e          state_q;
  logic [3:0]      insvc_q;
  logic [NSRC-1:0] s1_q, s2_q, s3_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] en_q, en_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic            ack_q;
  logic            irq_q;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] best_oh;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] latch;
  logic [3:0]      id;
  logic            acc;
  logic            wr;
  logic            rd;
  logic            claim;
  logic            complete;

  assign rise = s2_q & ~s3_q;
  assign cand = pend_q & en_q;

  always_comb begin
    id      = '0;
    best_oh = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        id          = 4'(i + 1);
        best_oh     = '0;
        best_oh[i]  = 1'b1;
      end
    end
  end

  // Register side-effects happen only on the acked beat.
  assign acc = i_wb_cyc & ack_q;
  assign wr  = acc & i_wb_we;
  assign rd  = acc & ~i_wb_we;

  assign claim    = rd & (addr == 3'd3) & (state_q == IDLE)
                  & (id != 4'd0);
  assign complete = wr & (addr == 3'd3) & (state_q == INSVC)
                  & (i_wb_dat == {4'd0, insvc_q});

  assign w1c = (wr && addr == 3'd0) ? i_wb_dat[NSRC-1:0] : '0;
  assign clr = claim ? (best_oh & edge_q) : '0;

  assign en_d   = (wr && addr == 3'd1) ? i_wb_dat[NSRC-1:0] : en_q;
  assign edge_d = (wr && addr == 3'd2) ? i_wb_dat[NSRC-1:0] : edge_q;

  // Latch restarts from zero whenever a source enters edge mode.
  assign latch  = ((pend_q & edge_q) & ~w1c & ~clr) | rise;
  assign pend_d = (edge_d & latch) | (~edge_d & s2_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      pend_q <= '0;
      en_q   <= '0;
      edge_q <= '0;
      ack_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      s1_q   <= irq_src;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      pend_q <= pend_d;
      en_q   <= en_d;
      edge_q <= edge_d;
      ack_q  <= i_wb_cyc & ~ack_q;
      irq_q  <= (state_q == IDLE) & (|cand);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      insvc_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (claim) begin
            state_q <= INSVC;
            insvc_q <= id;
          end
        end
        INSVC: begin
          if (complete) begin
            state_q <= IDLE;
            insvc_q <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    o_wb_rdt = '0;
    case (addr)
      3'd0:    o_wb_rdt = 8'(pend_q);
      3'd1:    o_wb_rdt = 8'(en_q);
      3'd2:    o_wb_rdt = 8'(edge_q);
      3'd3:    o_wb_rdt = (state_q == IDLE) ? {4'd0, id} : 8'd0;
      3'd4:    o_wb_rdt = {4'd0, insvc_q};
      default: o_wb_rdt = '0;
    endcase
  end

  assign o_wb_ack = ack_q;
  assign irq_o    = irq_q;

endmodule
